cnn_loop_counter: RTL and testbench

Parametrised three-level nested loop counter for the CNN datapath: generates (column, row, channel) coordinates plus a flat linear index for one feature-map sweep. It generalises the single 16-bit clear/keep counter used in the CNN controllers into a start/done-controlled sweep with programmable terminal values per level. It sits between the CNN layer FSM, which issues start and keep, and the buffer/weight address generators, which consume the coordinates.

---
 rtl/cnn_loop_counter_if.sv | 31 +++
 rtl/cnn_loop_counter.sv | 108 ++++++++++
 tb/tb_cnn_loop_counter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_loop_counter_if.sv
// Handshake and coordinate bus between the CNN layer FSM (master) and the
// nested loop counter (slave).
interface cnn_loop_counter_if #(
    parameter int CNT_W = 16,
    parameter int IDX_W = 32
);
    logic             start;
    logic             clear;
    logic             keep;
    logic [CNT_W-1:0] col_max;
    logic [CNT_W-1:0] row_max;
    logic [CNT_W-1:0] ch_max;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] ch;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             valid;
    logic             last;
    logic             done;

    modport master (
        output start, clear, keep, col_max, row_max, ch_max,
        input  col, row, ch, idx, busy, valid, last, done
    );

    modport slave (
        input  start, clear, keep, col_max, row_max, ch_max,
        output col, row, ch, idx, busy, valid, last, done
    );
endinterface

// File: rtl/cnn_loop_counter.sv
// Three-level (column, row, channel) sweep counter with a flat linear index,
// start/done control, stall via keep and synchronous abort via clear.
module cnn_loop_counter #(
    parameter int CNT_W = 16,
    parameter int IDX_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cnn_loop_counter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [CNT_W-1:0] col_r, row_r, ch_r;
    logic [CNT_W-1:0] col_max_r, row_max_r, ch_max_r;
    logic [IDX_W-1:0] idx_r;
    logic             busy_r, done_r;
    logic             at_last;

    assign at_last   = busy_r && (col_r == col_max_r) && (row_r == row_max_r) && (ch_r == ch_max_r);

    assign bus.col   = col_r;
    assign bus.row   = row_r;
    assign bus.ch    = ch_r;
    assign bus.idx   = idx_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.last  = at_last;
    assign bus.valid = busy_r & ~bus.keep & ~bus.clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            col_r     <= '0;
            row_r     <= '0;
            ch_r      <= '0;
            idx_r     <= '0;
            col_max_r <= '0;
            row_max_r <= '0;
            ch_max_r  <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (bus.clear) begin
            state  <= IDLE;
            col_r  <= '0;
            row_r  <= '0;
            ch_r   <= '0;
            idx_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        col_max_r <= bus.col_max;
                        row_max_r <= bus.row_max;
                        ch_max_r  <= bus.ch_max;
                        col_r     <= '0;
                        row_r     <= '0;
                        ch_r      <= '0;
                        idx_r     <= '0;
                        busy_r    <= 1'b1;
                        state     <= RUN;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    if (!bus.keep) begin
                        if (at_last) begin
                            col_r  <= '0;
                            row_r  <= '0;
                            ch_r   <= '0;
                            idx_r  <= '0;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                            // Innermost level wraps first; carry ripples outward.
                            if (col_r == col_max_r) begin
                                col_r <= '0;
                                if (row_r == row_max_r) begin
                                    row_r <= '0;
                                    ch_r  <= ch_r + CNT_ONE;
                                end else begin
                                    row_r <= row_r + CNT_ONE;
                                end
                            end else begin
                                col_r <= col_r + CNT_ONE;
                            end
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_loop_counter.sv
// Directed self-checking bench for cnn_loop_counter: sweeps, stalls, control
// priority, async reset and an 8-bit wrap case on a second instance.
module tb_cnn_loop_counter;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    cnn_loop_counter_if #(.CNT_W(16), .IDX_W(32)) bus ();
    cnn_loop_counter_if #(.CNT_W(8),  .IDX_W(32)) bus8 ();

    cnn_loop_counter #(.CNT_W(16), .IDX_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    cnn_loop_counter #(.CNT_W(8), .IDX_W(32)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input bit s, input bit c, input bit k,
                                  input int cm, input int rm, input int hm);
        bus.start   = s;
        bus.clear   = c;
        bus.keep    = k;
        bus.col_max = cm[15:0];
        bus.row_max = rm[15:0];
        bus.ch_max  = hm[15:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, ".busy"}, bus.busy, 0);
        check_output({tag, ".done"}, bus.done, 0);
        check_output({tag, ".col"},  bus.col, 0);
        check_output({tag, ".idx"},  bus.idx, 0);
    endtask

    // Runs one sweep from start acceptance to the done cycle. maxima inputs are
    // scrambled during RUN and an optional stray start is injected at point inj.
    task automatic do_sweep(input string tag, input int cm, input int rm, input int hm,
                            input int stall_a, input int stall_b, input int inj,
                            input int exp_cycles);
        int p, i, cyc;
        bit sa, sb, k;
        p = (cm + 1) * (rm + 1) * (hm + 1);
        apply_stimulus(1, 0, 0, cm, rm, hm);
        tick();
        i = 0; cyc = 0; sa = 0; sb = 0;
        while (i < p && cyc < exp_cycles + 4) begin
            k = 0;
            if (i == stall_a && !sa) begin k = 1; sa = 1; end
            else if (i == stall_b && !sb) begin k = 1; sb = 1; end
            apply_stimulus(i == inj, 0, k, 9, 9, 9);
            #1;
            check_output($sformatf("%s.col@%0d", tag, cyc), bus.col, i % (cm + 1));
            check_output($sformatf("%s.row@%0d", tag, cyc), bus.row, (i / (cm + 1)) % (rm + 1));
            check_output($sformatf("%s.ch@%0d",  tag, cyc), bus.ch,  i / ((cm + 1) * (rm + 1)));
            check_output($sformatf("%s.idx@%0d", tag, cyc), bus.idx, i);
            check_output($sformatf("%s.busy@%0d", tag, cyc), bus.busy, 1);
            check_output($sformatf("%s.valid@%0d", tag, cyc), bus.valid, !k);
            check_output($sformatf("%s.last@%0d", tag, cyc), bus.last, i == p - 1);
            check_output($sformatf("%s.done@%0d", tag, cyc), bus.done, 0);
            tick();
            if (!k) i++;
            cyc++;
        end
        apply_stimulus(0, 0, 0, 9, 9, 9);
        #1;
        check_output({tag, ".cycles"}, cyc, exp_cycles);
        check_output({tag, ".done"},   bus.done, 1);
        check_output({tag, ".busy"},   bus.busy, 0);
        check_output({tag, ".last"},   bus.last, 0);
        check_output({tag, ".valid"},  bus.valid, 0);
        check_output({tag, ".idx0"},   bus.idx, 0);
        check_output({tag, ".col0"},   bus.col, 0);
    endtask

    initial begin
        int last_seen;
        compared   = 0;
        mismatched = 0;
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        bus8.start = 0; bus8.clear = 0; bus8.keep = 0;
        bus8.col_max = 0; bus8.row_max = 0; bus8.ch_max = 0;
        #12;
        check_idle("reset");
        check_output("reset.last", bus.last, 0);
        rst = 1'b1;

        // Async reset in the middle of a sweep at col=3
        apply_stimulus(1, 0, 0, 5, 1, 0);
        tick();
        apply_stimulus(0, 0, 0, 5, 1, 0);
        tick(); tick(); tick();
        check_output("pre_rst.col", bus.col, 3);
        #2 rst = 1'b0;
        #1;
        check_idle("async_rst");
        check_output("async_rst.last", bus.last, 0);
        #2 rst = 1'b1;
        tick(); tick();
        check_idle("post_rst");

        $display("[TB] basic sweep");
        do_sweep("basic", 2, 1, 1, -1, -1, -1, 12);
        tick();
        check_idle("basic_after");

        $display("[TB] stall sweep");
        do_sweep("stall", 2, 1, 1, 4, 7, -1, 14);
        tick();
        check_idle("stall_after");

        do_sweep("single", 0, 0, 0, -1, -1, -1, 1);
        tick();
        check_idle("single_after");

        // Stray start mid-run, then a restart straight out of DONE
        do_sweep("rows", 0, 3, 0, -1, -1, 2, 4);
        do_sweep("restart", 1, 0, 1, -1, -1, -1, 4);
        tick();
        check_idle("restart_after");

        apply_stimulus(1, 1, 0, 4, 4, 4);
        tick();
        apply_stimulus(0, 0, 0, 4, 4, 4);
        #1;
        check_idle("clr_start");

        apply_stimulus(1, 0, 0, 3, 1, 0);
        tick();
        apply_stimulus(0, 0, 0, 3, 1, 0);
        tick();
        check_output("clr_run.col", bus.col, 1);
        apply_stimulus(1, 1, 0, 3, 1, 0);
        #1;
        check_output("clr_run.valid", bus.valid, 0);
        tick();
        apply_stimulus(0, 0, 0, 3, 1, 0);
        #1;
        check_idle("clr_run_after");

        $display("[TB] 8-bit wrap sweep");
        bus8.start = 1; bus8.col_max = 8'd255; bus8.row_max = 8'd0; bus8.ch_max = 8'd1;
        tick();
        bus8.start = 0;
        last_seen = 0;
        for (int i = 0; i < 512; i++) begin
            #1;
            if (bus8.last) last_seen++;
            if (i == 255 || i == 256 || i == 511) begin
                check_output($sformatf("w8.col@%0d", i), bus8.col, i % 256);
                check_output($sformatf("w8.ch@%0d", i),  bus8.ch,  i / 256);
                check_output($sformatf("w8.idx@%0d", i), bus8.idx, i);
                check_output($sformatf("w8.last@%0d", i), bus8.last, i == 511);
            end
            tick();
        end
        #1;
        check_output("w8.last_count", last_seen, 1);
        check_output("w8.done", bus8.done, 1);
        check_output("w8.busy", bus8.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
